usbfs_packet_tx: RTL and testbench
==================================

Name: usbfs_packet_tx

Overview:
- Packet-level transmitter directly downstream of the transaction controller.
- Accepts the `tp_sta`/`tp_pid` start command and pulls payload bytes via the `tp_byte_req`/`tp_byte`/`tp_fin_n` byte handshake.
- Serialises each packet LSB-first as PID, optional payload and CRC16 bits for the bit-level layer, which does SYNC, bit stuffing, NRZI and EOP.
- Handshake packets are PID only; data packets are PID + payload + CRC16.

Parameters:
- MAX_PAYLOAD, 10'd1023: payload byte cap. After this many bytes, no further bytes are requested and the CRC is sent.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tp_sta  in  1  one-cycle start-of-packet pulse from the transaction layer
- tp_pid  in  4  PID, sampled when tp_sta=1
- tp_byte_req  out  1  one-cycle request for the next payload byte
- tp_byte  in  8  payload byte, valid the cycle after tp_byte_req
- tp_fin_n  in  1  sampled the cycle after tp_byte_req: 1 = tp_byte valid, 0 = payload ended
- tx_sta  out  1  one-cycle pulse telling the bit layer to start SYNC
- tx_bit_req  in  1  bit layer requests the next bit
- tx_bit  out  1  bit answering the previous tx_bit_req
- tx_fin_n  out  1  registered with tx_bit: 1 = tx_bit valid, 0 = packet done (bit layer sends EOP)
- busy  out  1  packet in progress

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: tp_byte_req=0, tx_sta=0, tx_bit=0, tx_fin_n=0, busy=0, state=IDLE, crc=16'hFFFF. Reset mid-packet aborts immediately and requests nothing further.
- States: IDLE, PID, DATA, CRC, DONE.
- IDLE + tp_sta:
  - Latch shift={~tp_pid,tp_pid}, cnt=0, crc=16'hFFFF, bytes=0.
  - has_data = (tp_pid[1:0]==2'b11), i.e. DATA0/1/2/MDATA.
  - Next cycle: tx_sta=1, busy=1, state→PID.
- tp_sta while busy: ignored, with no effect on the current packet.
- Bit response: on each tx_bit_req, the next cycle drives tx_bit=shift[0] and tx_fin_n=1, then shift>>=1 and cnt++. tx_bit/tx_fin_n hold until the next response. tx_bit_req seen in IDLE/DONE: respond tx_fin_n=0.
- PID, bit 7 served:
  - If has_data and MAX_PAYLOAD≠0: assert tp_byte_req the same cycle. Next cycle: tp_fin_n=1 loads shift=tp_byte, bytes=1, →DATA; tp_fin_n=0 →CRC.
  - If has_data and MAX_PAYLOAD==0: →CRC.
  - Otherwise: →DONE.
- DATA:
  - Each served bit b updates crc: fb=crc[0]^b; crc=(crc>>1)^(fb?16'hA001:0).
  - On bit 7: if bytes==MAX_PAYLOAD →CRC, else issue tp_byte_req as in PID.
- CRC:
  - On entry, shift[15:0]=~crc.
  - 16 bits LSB-first, no CRC update, then →DONE.
- DONE: the next tx_bit_req is answered with tx_fin_n=0. Then busy=0 →IDLE.
- Timing:
  - The bit layer guarantees ≥2 cycles between tx_bit_req pulses, so the byte fetch (req cycle + 1) always completes before the next bit is needed.
  - A bit request coinciding with the byte-response cycle is a protocol violation. Flag it with an assertion only.
- Zero-length data packet: CRC bits are ~16'hFFFF = 16'h0000.
- Unknown PIDs are sent PID-only.
- Width rules: bytes 10 bits, cnt 4 bits; both saturate-free because they are bounded by state.

Decomposition:
- usbfs_pkg:
  - PID constants: ACK=4'h2, NAK=4'hA, STALL=4'hE, DATA0=4'h3, DATA1=4'hB.
  - CRC16_INIT=16'hFFFF, CRC16_POLY_REF=16'hA001.
  - State enum.
- Sub-module usbfs_crc16: 1-bit serial update with enable and init, 16-bit register.

Test Plan:
- tp_sta, tp_pid=4'h2 (ACK); bit requests every 5 cycles → bits LSB-first of 8'hD2. 9th request answered tx_fin_n=0. tp_byte_req never asserted.
- tp_pid=4'h3 (DATA0), first byte response tp_fin_n=0 → 8 PID bits of 8'hC3, 16 zero CRC bits, then tx_fin_n=0.
- tp_pid=4'hB, payload ASCII "123456789" (9 bytes) → PID 8'h4B, 72 data bits, CRC bytes 8'hC8 then 8'hB4 LSB-first (CRC-16/USB check 16'hB4C8). Exactly 10 tp_byte_req pulses.
- MAX_PAYLOAD=4, source always offers bytes → exactly 4 tp_byte_req pulses, then CRC of 4 bytes matches the model, then fin.
- rst=1 asserted mid-DATA → next cycle all outputs 0, busy=0. New tp_sta then sends a clean packet.
- Second tp_sta during a packet → ignored; the output bit stream is identical to the single-packet reference.

Source files
------------

// File: rtl/usbfs_pkg.sv
// USB full-speed packet transmitter shared definitions.
// PID codes, CRC16 constants and the packet FSM states.
package usbfs_pkg;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } tx_state_e;

  // DATA0/DATA1/DATA2/MDATA all end in 2'b11.
  function automatic logic pid_has_data(input logic [3:0] pid);
    return pid[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/usbfs_crc16.sv
// Serial CRC16 (reflected 0xA001) for USB data payloads.
// One bit per enabled cycle; init reloads 0xFFFF.
module usbfs_crc16
  import usbfs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  assign fb    = crc_q[0] ^ bit_i;
  assign crc_o = crc_q;

  // Next CRC value: init wins over a bit update.
  always_comb begin
    crc_d = crc_q;
    if (init_i)
      crc_d = CRC16_INIT;
    else if (en_i)
      crc_d = (crc_q >> 1) ^ (fb ? CRC16_POLY_REF : 16'h0000);
  end

  // CRC register.
  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC16_INIT;
    else     crc_q <= crc_d;
  end

endmodule

// File: rtl/usbfs_packet_tx.sv
// USB FS packet serialiser: PID, payload and CRC16, LSB-first.
// Bytes are pulled on demand; bits are served on request.
module usbfs_packet_tx
  import usbfs_pkg::*;
#(
  parameter logic [9:0] MAX_PAYLOAD = 10'd1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tp_sta,
  input  logic [3:0] tp_pid,
  output logic       tp_byte_req,
  input  logic [7:0] tp_byte,
  input  logic       tp_fin_n,
  output logic       tx_sta,
  input  logic       tx_bit_req,
  output logic       tx_bit,
  output logic       tx_fin_n,
  output logic       busy
);

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  bytes_q, bytes_d;
  logic        has_data_q, has_data_d;
  logic        fetch_q, fetch_d;
  logic        tx_sta_q, tx_sta_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_fin_n_q, tx_fin_n_d;
  logic        busy_q, busy_d;

  logic        byte_req;
  logic        crc_init;
  logic        crc_en;
  logic        more;
  logic [15:0] crc;

  usbfs_crc16 u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .bit_i  (shift_q[0]),
    .crc_o  (crc)
  );

  assign tp_byte_req = byte_req & ~rst;
  assign tx_sta      = tx_sta_q;
  assign tx_bit      = tx_bit_q;
  assign tx_fin_n    = tx_fin_n_q;
  assign busy        = busy_q;

  // Whether another payload byte should be fetched after this byte.
  always_comb begin
    if (state_q == ST_PID)
      more = has_data_q && (MAX_PAYLOAD != 10'd0);
    else
      more = (bytes_q != MAX_PAYLOAD);
  end

  // Packet FSM: next state, bit serving and byte fetch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    bytes_d    = bytes_q;
    has_data_d = has_data_q;
    fetch_d    = 1'b0;
    tx_sta_d   = 1'b0;
    tx_bit_d   = tx_bit_q;
    tx_fin_n_d = tx_fin_n_q;
    busy_d     = busy_q;
    byte_req   = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_bit_req) tx_fin_n_d = 1'b0;
        if (tp_sta) begin
          shift_d    = {~tp_pid, tp_pid};
          cnt_d      = 4'd0;
          bytes_d    = 10'd0;
          has_data_d = pid_has_data(tp_pid);
          crc_init   = 1'b1;
          tx_sta_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_PID;
        end
      end
      ST_PID, ST_DATA: begin
        if (fetch_q) begin
          cnt_d = 4'd0;
          if (tp_fin_n) begin
            shift_d = tp_byte;
            bytes_d = bytes_q + 10'd1;
            state_d = ST_DATA;
          end else begin
            state_d = ST_CRC;
          end
        end else if (tx_bit_req) begin
          tx_bit_d   = shift_q[0];
          tx_fin_n_d = 1'b1;
          shift_d    = {1'b0, shift_q[7:1]};
          cnt_d      = cnt_q + 4'd1;
          crc_en     = (state_q == ST_DATA);
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (state_q == ST_PID && !has_data_q)
              state_d = ST_DONE;
            else if (!more)
              state_d = ST_CRC;
            else begin
              byte_req = 1'b1;
              fetch_d  = 1'b1;
            end
          end
        end
      end
      ST_CRC: begin
        if (tx_bit_req) begin
          tx_bit_d   = ~crc[cnt_q];
          tx_fin_n_d = 1'b1;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d   = 4'd0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (tx_bit_req) begin
          tx_fin_n_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 4'd0;
      bytes_q    <= 10'd0;
      has_data_q <= 1'b0;
      fetch_q    <= 1'b0;
      tx_sta_q   <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_fin_n_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      bytes_q    <= bytes_d;
      has_data_q <= has_data_d;
      fetch_q    <= fetch_d;
      tx_sta_q   <= tx_sta_d;
      tx_bit_q   <= tx_bit_d;
      tx_fin_n_q <= tx_fin_n_d;
      busy_q     <= busy_d;
    end
  end

  // A bit request must not land on the byte response cycle.
  always_ff @(posedge clk) begin
    if (!rst && fetch_q)
      assert (!tx_bit_req)
        else $error("tx_bit_req during byte response cycle");
  end

endmodule

// File: tb/tb_usbfs_packet_tx.sv
// Directed bench for usbfs_packet_tx.
// Two instances: default payload cap and a cap of 4 bytes.
module tb_usbfs_packet_tx;
  import usbfs_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tp_sta1 = 1'b0;
  logic       tp_sta2 = 1'b0;
  logic [3:0] tp_pid = 4'h0;
  logic [7:0] tp_byte = 8'h00;
  logic       tp_fin_n = 1'b0;
  logic       tx_bit_req = 1'b0;

  logic tp_byte_req1, tx_sta1, tx_bit1, tx_fin_n1, busy1;
  logic tp_byte_req2, tx_sta2, tx_bit2, tx_fin_n2, busy2;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int src_len = 0;
  int src_idx = 0;
  logic [7:0] src_mem [0:15];
  logic got_q[$];
  logic exp_q[$];
  logic fin;
  logic [15:0] c4;

  always #5 clk = ~clk;

  usbfs_packet_tx #(.MAX_PAYLOAD(10'd1023)) dut1 (
    .clk(clk), .rst(rst), .tp_sta(tp_sta1), .tp_pid(tp_pid),
    .tp_byte_req(tp_byte_req1), .tp_byte(tp_byte),
    .tp_fin_n(tp_fin_n), .tx_sta(tx_sta1),
    .tx_bit_req(tx_bit_req), .tx_bit(tx_bit1),
    .tx_fin_n(tx_fin_n1), .busy(busy1)
  );

  usbfs_packet_tx #(.MAX_PAYLOAD(10'd4)) dut2 (
    .clk(clk), .rst(rst), .tp_sta(tp_sta2), .tp_pid(tp_pid),
    .tp_byte_req(tp_byte_req2), .tp_byte(tp_byte),
    .tp_fin_n(tp_fin_n), .tx_sta(tx_sta2),
    .tx_bit_req(tx_bit_req), .tx_bit(tx_bit2),
    .tx_fin_n(tx_fin_n2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CRC-16/USB reference over src_mem[0..n-1], final value inverted.
  function automatic logic [15:0] crc_usb(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ src_mem[k][i];
        c = (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
      end
    return ~c;
  endfunction

  task automatic get_bit(input int sel, output logic b, output logic f);
    logic rq;
    @(negedge clk);
    tx_bit_req = 1'b1;
    #1;
    rq = (sel == 1) ? tp_byte_req1 : tp_byte_req2;
    if (rq) begin
      req_cnt++;
      if (src_idx < src_len) begin
        tp_byte = src_mem[src_idx];
        tp_fin_n = 1'b1;
        src_idx++;
      end else begin
        tp_byte = 8'h00;
        tp_fin_n = 1'b0;
      end
    end
    @(negedge clk);
    tx_bit_req = 1'b0;
    b = (sel == 1) ? tx_bit1 : tx_bit2;
    f = (sel == 1) ? tx_fin_n1 : tx_fin_n2;
    repeat (3) @(negedge clk);
  endtask

  task automatic start(input int sel, input logic [3:0] pid);
    req_cnt = 0;
    src_idx = 0;
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    tp_pid = pid;
    if (sel == 1) tp_sta1 = 1'b1;
    else tp_sta2 = 1'b1;
    @(negedge clk);
    tp_sta1 = 1'b0;
    tp_sta2 = 1'b0;
    chk("tx_sta", (sel == 1) ? tx_sta1 : tx_sta2, 1);
    chk("busy_start", (sel == 1) ? busy1 : busy2, 1);
  endtask

  task automatic collect(input int sel, input int nmax, output logic fo);
    logic b, f;
    fo = 1'b0;
    for (int n = 0; n < nmax; n++) begin
      get_bit(sel, b, f);
      if (!f) begin
        fo = 1'b1;
        return;
      end
      got_q.push_back(b);
    end
  endtask

  task automatic exp_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
  endtask

  task automatic cmp_stream(input string tag, input int sel);
    logic [7:0] g, e;
    chk({tag, " fin"}, fin, 1);
    chk({tag, " nbits"}, got_q.size(), exp_q.size());
    for (int i = 0; i + 8 <= got_q.size() && i + 8 <= exp_q.size();
         i += 8) begin
      for (int j = 0; j < 8; j++) begin
        g[j] = got_q[i+j];
        e[j] = exp_q[i+j];
      end
      chk($sformatf("%s byte%0d", tag, i / 8), g, e);
    end
    chk({tag, " busy_end"}, (sel == 1) ? busy1 : busy2, 0);
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) src_mem[i] = 8'h31 + 8'(i);
    src_len = 9;
  endtask

  task automatic exp_digits();
    exp_byte(8'h4B);
    for (int i = 0; i < 9; i++) exp_byte(8'h31 + 8'(i));
    exp_byte(8'hC8);
    exp_byte(8'hB4);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset dut1", {tp_byte_req1, tx_sta1, tx_bit1, tx_fin_n1, busy1}, 0);
    chk("reset dut2", {tp_byte_req2, tx_sta2, tx_bit2, tx_fin_n2, busy2}, 0);
    rst = 1'b0;

    // ACK: PID only
    src_len = 0;
    start(1, PID_ACK);
    collect(1, 400, fin);
    exp_byte(8'hD2);
    cmp_stream("ack", 1);
    chk("ack reqs", req_cnt, 0);

    // DATA0 with empty payload
    src_len = 0;
    start(1, PID_DATA0);
    collect(1, 400, fin);
    exp_byte(8'hC3);
    exp_byte(8'h00);
    exp_byte(8'h00);
    cmp_stream("zlp", 1);
    chk("zlp reqs", req_cnt, 1);

    // DATA1 "123456789" -> CRC check value B4C8
    load_digits();
    start(1, PID_DATA1);
    collect(1, 400, fin);
    exp_digits();
    cmp_stream("digits", 1);
    chk("digits reqs", req_cnt, 10);

    // Payload cap of 4 with an endless source
    src_mem[0] = 8'hA5;
    src_mem[1] = 8'h5A;
    src_mem[2] = 8'h01;
    src_mem[3] = 8'hFF;
    for (int i = 4; i < 16; i++) src_mem[i] = 8'h77;
    src_len = 16;
    c4 = crc_usb(4);
    start(2, PID_DATA0);
    collect(2, 400, fin);
    exp_byte(8'hC3);
    for (int i = 0; i < 4; i++) exp_byte(src_mem[i]);
    exp_byte(c4[7:0]);
    exp_byte(c4[15:8]);
    cmp_stream("cap4", 2);
    chk("cap4 reqs", req_cnt, 4);

    // Reset in the middle of the payload
    load_digits();
    start(1, PID_DATA1);
    collect(1, 20, fin);
    chk("mid fin", fin, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort outs",
        {tp_byte_req1, tx_sta1, tx_bit1, tx_fin_n1, busy1}, 0);
    rst = 1'b0;
    src_len = 0;
    start(1, PID_ACK);
    collect(1, 400, fin);
    exp_byte(8'hD2);
    cmp_stream("post_rst", 1);
    chk("post_rst reqs", req_cnt, 0);

    // Extra tp_sta while busy must change nothing
    load_digits();
    start(1, PID_DATA1);
    collect(1, 5, fin);
    @(negedge clk);
    tp_pid = PID_ACK;
    tp_sta1 = 1'b1;
    @(negedge clk);
    tp_sta1 = 1'b0;
    tp_pid = PID_DATA1;
    @(negedge clk);
    chk("dup tx_sta", tx_sta1, 0);
    collect(1, 400, fin);
    exp_digits();
    cmp_stream("dup", 1);
    chk("dup reqs", req_cnt, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
